// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: controller instruction codes and sequencer FSM states
package pc_sequencer_pkg;
  localparam logic [3:0] DEVICE_CONTROLLER = 4'hF;
  localparam logic [3:0] PORT_JUMP_LARGER  = 4'h1;
  localparam logic [3:0] PORT_JUMP_SMALLER = 4'h2;
  localparam logic [3:0] PORT_JUMP_EQUAL   = 4'h3;
  localparam logic [3:0] PORT_JUMP_DIRECT  = 4'h4;
  localparam logic [3:0] PORT_WAIT         = 4'h5;
  localparam logic [3:0] PORT_STOP         = 4'h6;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_ARG, S_WAIT, S_STOP} state_t;
endpackage

// File: rtl/pc_jump_decode.sv
// pc_jump_decode: classifies a controller instruction and resolves its jump condition
module pc_jump_decode
  import pc_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] ir,
  input  logic                  flag_gt,
  input  logic                  flag_lt,
  input  logic                  flag_eq,
  output logic                  is_ctrl,
  output logic                  needs_arg,
  output logic                  take_jump,
  output logic                  is_wait,
  output logic                  is_stop
);
  logic [3:0] port;
  logic       is_jump;
  always_comb begin
    port      = ir[3:0];
    is_ctrl   = ir[7:4] == DEVICE_CONTROLLER;
    is_jump   = is_ctrl && port inside {PORT_JUMP_LARGER, PORT_JUMP_SMALLER, PORT_JUMP_EQUAL, PORT_JUMP_DIRECT};
    is_wait   = is_ctrl && port == PORT_WAIT;
    is_stop   = is_ctrl && port == PORT_STOP;
    needs_arg = is_jump || is_wait;
    take_jump = is_jump && (port == PORT_JUMP_DIRECT ||
                            (port == PORT_JUMP_LARGER  && flag_gt) ||
                            (port == PORT_JUMP_SMALLER && flag_lt) ||
                            (port == PORT_JUMP_EQUAL   && flag_eq));
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC, fetches words, executes controller ops and issues the rest
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int WAIT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  output logic                  o_fetch_req,
  output logic [ADDR_WIDTH-1:0] o_fetch_addr,
  input  logic                  i_fetch_ack,
  input  logic [DATA_WIDTH-1:0] i_fetch_data,
  input  logic                  i_flag_gt,
  input  logic                  i_flag_lt,
  input  logic                  i_flag_eq,
  output logic [DATA_WIDTH-1:0] o_ir,
  output logic                  o_ir_en,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic                  o_busy,
  output logic                  o_stopped
);
  state_t                state;
  logic [DATA_WIDTH-1:0] ir_q;
  logic [ADDR_WIDTH-1:0] pc, pc_inc, arg_pc;
  logic [WAIT_WIDTH-1:0] wait_cnt, operand_wait;
  logic                  is_ctrl, needs_arg, take_jump, is_wait, is_stop, wait_go;

  pc_jump_decode #(.DATA_WIDTH(DATA_WIDTH)) u_decode (
    .ir(ir_q), .flag_gt(i_flag_gt), .flag_lt(i_flag_lt), .flag_eq(i_flag_eq),
    .is_ctrl(is_ctrl), .needs_arg(needs_arg), .take_jump(take_jump),
    .is_wait(is_wait), .is_stop(is_stop)
  );

  // Operands are cast to the target width: upper bits dropped, narrower ones zero-extended
  always_comb begin
    pc_inc       = pc + ADDR_WIDTH'(1);
    arg_pc       = take_jump ? ADDR_WIDTH'(i_fetch_data) : pc_inc;
    operand_wait = WAIT_WIDTH'(i_fetch_data);
    wait_go      = is_wait && operand_wait != '0;
  end

  assign o_pc = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      pc           <= '0;
      ir_q         <= '0;
      wait_cnt     <= '0;
      o_fetch_req  <= 1'b0;
      o_fetch_addr <= '0;
      o_ir         <= '0;
      o_ir_en      <= 1'b0;
      o_busy       <= 1'b0;
      o_stopped    <= 1'b0;
    end else begin
      o_ir_en <= 1'b0;
      case (state)
        S_IDLE, S_STOP: if (i_start) begin
          state        <= S_FETCH;
          pc           <= '0;
          o_fetch_req  <= 1'b1;
          o_fetch_addr <= '0;
          o_busy       <= 1'b1;
          o_stopped    <= 1'b0;
        end
        S_FETCH: if (i_fetch_ack) begin
          state       <= S_DECODE;
          ir_q        <= i_fetch_data;
          pc          <= pc_inc;
          o_fetch_req <= 1'b0;
        end
        S_DECODE: begin
          if (!is_ctrl) begin
            o_ir    <= ir_q;
            o_ir_en <= 1'b1;
          end
          state        <= is_stop ? S_STOP : needs_arg ? S_ARG : S_FETCH;
          o_fetch_req  <= !is_stop;
          o_fetch_addr <= pc;
          o_busy       <= !is_stop;
          o_stopped    <= is_stop;
        end
        S_ARG: if (i_fetch_ack) begin
          pc           <= arg_pc;
          wait_cnt     <= operand_wait;
          state        <= wait_go ? S_WAIT : S_FETCH;
          o_fetch_req  <= !wait_go;
          o_fetch_addr <= arg_pc;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - WAIT_WIDTH'(1);
          if (wait_cnt == WAIT_WIDTH'(1)) begin
            state        <= S_FETCH;
            o_fetch_req  <= 1'b1;
            o_fetch_addr <= pc;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
